// File: rtl/scale_buffer_writer.sv
// Scaled-buffer writer: turns accepted scaler requests into source-RAM reads and,
// RD_LAT cycles later, sequential scaled-buffer writes, with occupancy-based backpressure.
module scale_buffer_writer #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 12200,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_En,
    input  logic [18:0]       addr_request,
    input  logic [18:0]       addr_scale,
    input  logic              endScale,
    output logic              src_rd_en,
    output logic [18:0]       src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              buf_we,
    output logic [13:0]       buf_addr,
    output logic [DATA_W-1:0] buf_data,
    input  logic              buf_free,
    output logic              buf_full,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [RD_LAT:1]       vld_pipe;
    logic [RD_LAT:1][13:0] idx_pipe;
    logic [13:0]           wr_idx;
    logic [18:0]           req_cnt;
    logic [14:0]           occ;
    logic                  err_flag;
    logic                  in_run;
    logic                  accept;
    logic                  upstream_busy;
    logic                  free_ok;
    logic [15:0]           in_flight;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The read sitting at the last stage is written this cycle, so it does not hold DRAIN.
    always_comb begin
        upstream_busy = 1'b0;
        for (int i = 1; i < RD_LAT; i++) upstream_busy = upstream_busy | vld_pipe[i];
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     if (endScale) state_nxt = DRAIN;
                DRAIN:   if (!upstream_busy) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_run = (state == RUN);
        done   = (state == DONE);
    end

    always_comb begin
        in_flight = '0;
        for (int i = 1; i <= RD_LAT; i++) in_flight = in_flight + 16'(vld_pipe[i]);
    end

    assign buf_full  = ({1'b0, occ} + in_flight) >= 16'(BUF_DEPTH);
    assign accept    = in_run && en && wr_En && !buf_full;
    assign src_rd_en = accept;
    assign src_addr  = accept ? addr_scale : '0;

    // Gating with en drops a read landing in the same cycle en falls.
    assign buf_we   = vld_pipe[RD_LAT] && en;
    assign buf_addr = buf_we ? idx_pipe[RD_LAT] : '0;
    assign buf_data = buf_we ? src_data : '0;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
            wr_idx   <= '0;
            req_cnt  <= '0;
        end else begin
            vld_pipe[1] <= accept;
            idx_pipe[1] <= wr_idx;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
            if (state == IDLE) begin
                wr_idx  <= '0;
                req_cnt <= '0;
            end else if (accept) begin
                wr_idx  <= (wr_idx == 14'(BUF_DEPTH - 1)) ? '0 : wr_idx + 14'd1;
                req_cnt <= req_cnt + 19'd1;
            end
        end
    end

    // Sticky diagnostic: scaler's pixel index disagrees with our own request count.
    always_ff @(posedge clk) begin
        if (rst)                                    err_flag <= 1'b0;
        else if (accept && addr_request != req_cnt) err_flag <= 1'b1;
        else                                        err_flag <= err_flag;
    end

    assign free_ok = buf_free && (occ != '0);

    always_ff @(posedge clk) begin
        if (rst)                     occ <= '0;
        else if (buf_we && !free_ok) occ <= occ + 15'd1;
        else if (!buf_we && free_ok) occ <= occ - 15'd1;
    end

endmodule
